rand_source: RTL and testbench

Pseudo-random number source for the 10-bit magnitude-compare stage: a 10-bit XNOR LFSR is advanced a fixed number of steps on each player "draw" request, and the result is presented as a stable operand with a valid flag. The block sits directly upstream of the comparator and drives its second operand. The comparator consumes `value` only while `valid` is high.

---
 rtl/rand_source.sv | 103 ++++++++++
 tb/tb_rand_source.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/rand_source.sv
// Draw-triggered 10-bit XNOR LFSR operand source for the magnitude comparator.
// Optional macro RAND_LOCKUP_GUARD_EN forces the all-ones lock-up state to zero.
module rand_source #(
    parameter int              WIDTH      = 10,
    parameter logic [WIDTH-1:0] SEED      = 10'h000,
    parameter int              MIX_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             draw,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    output logic [WIDTH-1:0] value,
    output logic             valid,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, MIX, READY} state_t;

    localparam logic [3:0] LAST = 4'(MIX_CYCLES - 1);

    state_t           state, state_n;
    logic [3:0]       cnt, cnt_n;
    logic [WIDTH-1:0] lfsr, lfsr_n;
    logic [WIDTH-1:0] value_n;
    logic             valid_n;
    logic             draw_prev;
    logic             rise;

    // Seeds pass through unchanged unless the lock-up guard is built in.
    function automatic logic [WIDTH-1:0] fix_seed(input logic [WIDTH-1:0] s);
`ifdef RAND_LOCKUP_GUARD_EN
        if (&s) return '0;
`endif
        return s;
    endfunction

    function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] s);
`ifdef RAND_LOCKUP_GUARD_EN
        if (&s) return '0;
`endif
        return {s[WIDTH-2:0], ~(s[9] ^ s[6])};
    endfunction

    assign rise = draw & ~draw_prev;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        lfsr_n  = lfsr;
        value_n = value;
        valid_n = valid;
        if (seed_load) begin
            // A coincident draw edge is dropped along with any partial mix.
            lfsr_n  = fix_seed(seed_in);
            state_n = IDLE;
            cnt_n   = '0;
            valid_n = 1'b0;
        end else begin
            case (state)
                IDLE, READY: begin
                    if (rise) begin
                        state_n = MIX;
                        cnt_n   = '0;
                        valid_n = 1'b0;
                    end
                end
                MIX: begin
                    lfsr_n = step(lfsr);
                    cnt_n  = cnt + 4'd1;
                    if (cnt == LAST) begin
                        value_n = lfsr_n;
                        valid_n = 1'b1;
                        state_n = READY;
                        cnt_n   = '0;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            lfsr      <= fix_seed(SEED);
            value     <= '0;
            valid     <= 1'b0;
            busy      <= 1'b0;
            draw_prev <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            lfsr      <= lfsr_n;
            value     <= value_n;
            valid     <= valid_n;
            busy      <= (state_n == MIX);
            draw_prev <= draw;
        end
    end

endmodule

// File: tb/tb_rand_source.sv
// Scoreboard bench for rand_source: transaction-level LFSR model feeds an
// expected-value queue that a separate monitor drains on each completed draw.
module tb_rand_source;

    localparam int MIX = 4;
    localparam logic [9:0] SEED = 10'h000;

    logic       clk = 1'b0;
    logic       reset, draw, seed_load;
    logic [9:0] seed_in;
    logic [9:0] value;
    logic       valid, busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [9:0] exp_q[$];

    // Model state
    int         m_lfsr, m_res, m_left, m_value;
    bit         m_valid, m_prev;

    rand_source #(.WIDTH(10), .SEED(SEED), .MIX_CYCLES(MIX)) dut (
        .clk(clk), .reset(reset), .draw(draw), .seed_load(seed_load),
        .seed_in(seed_in), .value(value), .valid(valid), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int mfix(input int s);
`ifdef RAND_LOCKUP_GUARD_EN
        if (s == 1023) return 0;
`endif
        return s;
    endfunction

    // Advance n steps: shift left, feed back XNOR of bits 9 and 6.
    function automatic int msteps(input int s, input int n);
        int x = s;
        for (int i = 0; i < n; i++) begin
`ifdef RAND_LOCKUP_GUARD_EN
            if (x == 1023) begin x = 0; continue; end
`endif
            x = ((x * 2) % 1024) + ((((x / 512) % 2) == ((x / 64) % 2)) ? 1 : 0);
        end
        return x;
    endfunction

    task automatic cycle(input bit d, input bit sl = 0, input logic [9:0] si = '0,
                         input bit rs = 0);
        bit rise;
        draw = d; seed_load = sl; seed_in = si; reset = rs;
        @(posedge clk);
        rise = d && !m_prev;
        m_prev = d;
        if (rs) begin
            if (m_left > 0) void'(exp_q.pop_back());
            m_lfsr = mfix(int'(SEED)); m_left = 0; m_valid = 0; m_value = 0; m_prev = 0;
        end else if (sl) begin
            if (m_left > 0) void'(exp_q.pop_back());
            m_lfsr = mfix(int'(si)); m_left = 0; m_valid = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin m_valid = 1; m_value = m_res; end
        end else if (rise) begin
            m_res = msteps(m_lfsr, MIX);
            m_lfsr = m_res; m_left = MIX; m_valid = 0;
            exp_q.push_back(10'(m_res));
        end
        #1;
        chk("busy", int'(busy), (m_left > 0) ? 1 : 0);
        chk("valid", int'(valid), int'(m_valid));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0);
    endtask

    // Monitor: pop on each new valid, and require value stable while valid holds.
    logic       mon_pv = 1'b0;
    logic [9:0] mon_val = '0;
    always @(negedge clk) begin
        if (valid && !mon_pv) begin
            if (exp_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL unexpected_draw: got %0h expected no draw", value);
            end else begin
                chk("draw_value", int'(value), int'(exp_q.pop_front()));
            end
        end else if (valid && mon_pv) begin
            chk("value_stable", int'(value), int'(mon_val));
        end
        mon_pv  <= valid;
        mon_val <= value;
    end

    initial begin
        m_lfsr = 0; m_left = 0; m_value = 0; m_valid = 0; m_prev = 0; m_res = 0;
        draw = 0; seed_load = 0; seed_in = '0; reset = 1;
        cycle(0, 0, '0, 1);
        cycle(0, 0, '0, 1);
        chk("reset_value", int'(value), 0);
        chk("reset_valid", int'(valid), 0);
        chk("reset_busy", int'(busy), 0);

        // First two draws from seed 0
        cycle(1); idle(6);
        chk("first_draw", int'(value), 10'h00F);
        cycle(1); idle(6);
        chk("second_draw", int'(value), 10'h0FE);

        // Seed load collides with draw edge: edge dropped, value held
        cycle(1, 1, 10'h000);
        chk("collide_valid", int'(valid), 0);
        chk("collide_value", int'(value), 10'h0FE);
        idle(3);
        chk("collide_idle_busy", int'(busy), 0);
        cycle(1); idle(6);
        chk("after_collide", int'(value), 10'h00F);

        // Held draw gives exactly one result
        cycle(0, 0, '0, 1);
        for (int i = 0; i < 20; i++) cycle(1);
        chk("held_draw", int'(value), 10'h00F);
        chk("held_valid", int'(valid), 1);
        idle(2);

        // Second edge during MIX is ignored
        cycle(0, 0, '0, 1);
        cycle(1); cycle(0); cycle(1); idle(8);
        chk("mix_ignore", int'(value), 10'h00F);

        // Reset on the second MIX cycle abandons the draw
        cycle(1); cycle(0); cycle(0, 0, '0, 1);
        chk("midmix_value", int'(value), 0);
        chk("midmix_busy", int'(busy), 0);
        cycle(1); idle(6);
        chk("post_reset_draw", int'(value), 10'h00F);

        // Lock-up seed
        cycle(0, 1, 10'h3FF);
        for (int k = 0; k < 3; k++) begin
            cycle(1); idle(6);
`ifdef RAND_LOCKUP_GUARD_EN
            if (k == 0) chk("lockup_guard", int'(value), 10'h00F);
`else
            chk("lockup_stuck", int'(value), 10'h3FF);
`endif
        end

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            bit d, sl, rs;
            d  = ($urandom_range(0, 2) == 0);
            sl = ($urandom_range(0, 29) == 0);
            rs = ($urandom_range(0, 79) == 0);
            cycle(d, sl, 10'($urandom_range(0, 1023)), rs);
        end
        idle(MIX + 3);
        chk("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
